// File: rtl/ram_sp_clr.sv
// Single-port RAM with synchronous write, registered read + valid strobe,
// and a clear sequencer that fills the array with CLEAR_VAL after reset or on request.
module ram_sp_clr #(
  parameter int                 DATA_W    = 4,
  parameter int                 ADDR_W    = 4,
  parameter int                 DEPTH     = 16,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_req,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range, acc, wr_en, rd_en;
  logic [IDX_W-1:0]  aidx, cidx;
  logic [DATA_W-1:0] rd_word;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  // A clear request wins over any access presented in the same cycle.
  assign acc      = (state == READY) && !clr_req;
  assign wr_en    = acc && we && in_range;
  assign rd_en    = acc && re;
  assign aidx     = addr[IDX_W-1:0];
  assign cidx     = cnt[IDX_W-1:0];
  assign busy     = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      READY: begin
        if (clr_req) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Array has no reset; the reset edge itself leaves contents untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[cidx] <= CLEAR_VAL;
      else if (wr_en)
        mem[aidx] <= data_in;
    end
  end

  // Write-first on a same-cycle write; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = we ? data_in : mem[aidx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) data_out <= rd_word;
    end
  end

endmodule
